// File: rtl/seq_101011_gen.sv
// Serial frame generator. Sends a burst of `count` frames (0 counts as 1).
// Each frame is PATTERN, MSB first. Frames are separated by GAP idle cycles,
// and a single done cycle follows the last frame.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-low reset
//   start - begin a burst (sampled only in IDLE)
//   count - frames per burst, latched at start
//   out   - serial data (registered)
//   valid - out carries a frame or parity bit (registered)
//   busy  - burst in progress, including the done cycle (registered)
//   done  - one-cycle pulse after the last frame (registered)
module seq_101011_gen #(
    parameter int unsigned      WIDTH   = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b101011,
    parameter int unsigned      GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count,
    output logic       out,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned IDX_W = 4;
    // Zero-extended so a 4-bit index never selects past the vector.
    localparam logic [15:0] PAT_EXT = 16'(PATTERN);
`ifdef SEQ_GEN_PARITY_EN
    localparam logic PAR_BIT = ^PATTERN;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef SEQ_GEN_PARITY_EN
        ST_PAR,
`endif
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic [3:0]       frames, frames_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             frame_end;
    logic             out_n, valid_n, busy_n, done_n;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            frames  <= '0;
            gap_cnt <= '0;
            out     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            frames  <= frames_n;
            gap_cnt <= gap_cnt_n;
            out     <= out_n;
            valid   <= valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next state and counters. Outputs are decoded from the next state, so
    // the registered outputs track the state register cycle for cycle.
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        frames_n  = frames;
        gap_cnt_n = gap_cnt;
        frame_end = 1'b0;
        out_n     = 1'b0;
        valid_n   = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_SHIFT;
                    bit_idx_n = IDX_W'(WIDTH - 1);
                    frames_n  = (count == 4'd0) ? 4'd1 : count;
                end
            end
            ST_SHIFT: begin
                if (bit_idx == '0) begin
`ifdef SEQ_GEN_PARITY_EN
                    state_n = ST_PAR;
`else
                    frame_end = 1'b1;
`endif
                end else begin
                    bit_idx_n = bit_idx - IDX_W'(1);
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR: frame_end = 1'b1;
`endif
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_n   = ST_SHIFT;
                    bit_idx_n = IDX_W'(WIDTH - 1);
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Frame boundary: the frame with frames==1 is the last one.
        if (frame_end) begin
            frames_n = frames - 4'd1;
            if (frames == 4'd1) begin
                state_n = ST_DONE;
            end else if (GAP > 0) begin
                state_n   = ST_GAP;
                gap_cnt_n = 4'(GAP - 1);
            end else begin
                state_n   = ST_SHIFT;
                bit_idx_n = IDX_W'(WIDTH - 1);
            end
        end

        case (state_n)
            ST_SHIFT: begin
                out_n   = PAT_EXT[bit_idx_n];
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR: begin
                out_n   = PAR_BIT;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
`endif
            ST_GAP:  busy_n = 1'b1;
            ST_DONE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_101011_gen.sv
// Directed bench for seq_101011_gen with default parameters (101011, GAP=1).
module tb_seq_101011_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic       out, valid, busy, done;

    int n_vec;
    int n_err;

`ifdef SEQ_GEN_PARITY_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif
    localparam int PERIOD = FL + 1;

    seq_101011_gen dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .count(count),
        .out  (out),
        .valid(valid),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {done,busy,valid,out} in cycle c (c=1 is the cycle after the
    // start edge) of an n-frame burst, hand-derived from the frame timeline.
    function automatic logic [3:0] exp_at(int c, int n);
        logic [5:0] pat;
        int done_c, pos;
        pat    = 6'b101011;
        done_c = (n - 1) * PERIOD + FL + 1;
        pos    = (c - 1) % PERIOD;
        if (c == done_c) return 4'b1100;
        if (c > done_c)  return 4'b0000;
        if (pos < 6)     return {3'b011, pat[5 - pos]};
        if (pos < FL)    return 4'b0110;   // parity bit of 101011 is 0
        return 4'b0100;                     // gap cycle
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        count = 4'd1;
        repeat (2) step();
        n_vec++;
        if ({done, busy, valid, out} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset: got %b want 0000", {done, busy, valid, out});
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_vec++;
        if ({done, busy, valid, out} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 0000", {done, busy, valid, out});
        end
    endtask

    task automatic test_burst(input logic [3:0] cnt, input int n, input string name);
        int last;
        last  = (n - 1) * PERIOD + FL + 2;
        count = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            n_vec++;
            if ({done, busy, valid, out} !== exp_at(c, n)) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %b want %b", name, c,
                         {done, busy, valid, out}, exp_at(c, n));
            end
        end
    endtask

    task automatic test_restart_ignored();
        int last, dones;
        last  = PERIOD + FL + 2;
        dones = 0;
        count = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            if (done) dones++;
            n_vec++;
            if ({done, busy, valid, out} !== exp_at(c, 2)) begin
                n_err++;
                $display("FAIL restart cycle %0d: got %b want %b", c,
                         {done, busy, valid, out}, exp_at(c, 2));
            end
            if (c == 2) begin
                start = 1'b1;
                count = 4'd5;
            end else if (c == 3) begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL restart_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        extra = 0;
        count = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();                       // cycle 3, mid-frame
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({done, busy, valid, out} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0000", {done, busy, valid, out});
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy || valid) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL post_reset_activity: got %0d active cycles want 0", extra);
        end
        test_burst(4'd1, 1, "after_reset");
    endtask

    task automatic test_held_start();
        int guard;
        count = 4'd1;
        start = 1'b1;
        step();
        for (int c = 2; c <= FL + 2; c++) step();
        n_vec++;
        if ({done, busy, valid, out} !== 4'b0000) begin
            n_err++;
            $display("FAIL held_idle: got %b want 0000", {done, busy, valid, out});
        end
        step();
        n_vec++;
        if ({done, busy, valid, out} !== 4'b0111) begin
            n_err++;
            $display("FAIL held_restart: got %b want 0111", {done, busy, valid, out});
        end
        start = 1'b0;
        guard = 0;
        while (busy && guard < 50) begin
            step();
            guard++;
        end
        n_vec++;
        if (busy) begin
            n_err++;
            $display("FAIL held_drain: busy=%b after %0d cycles, want 0", busy, guard);
        end
        step();
    endtask

    task automatic test_loopback();
        logic [5:0] hist;
        int z, last;
        hist  = '0;
        z     = 0;
        last  = 3 * PERIOD + FL + 2;
        count = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            // Non-overlapping 101011 detector on the raw serial line.
            hist = {hist[4:0], out};
            if (hist == 6'b101011) begin
                z++;
                hist = '0;
            end
        end
        n_vec++;
        if (z != 4) begin
            n_err++;
            $display("FAIL loopback_z: got %0d pulses want 4", z);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_burst(4'd1, 1, "single");
        test_burst(4'd3, 3, "three");
        test_burst(4'd0, 1, "count_zero");
        test_restart_ignored();
        test_reset_mid();
        test_held_start();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
